upd7800_clkgen: RTL and testbench

UPD7800_CLKGEN -- requirements
Module: upd7800_clkgen

---
 rtl/upd7800_clkgen.sv | 129 ++++++++++++
 tb/tb_upd7800_clkgen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/upd7800_clkgen.sv
// Four-phase clock strobe sequencer and stretched CPU reset for the uPD7800 core.
// Optional single-step input is compiled in with `define UPD7800_CLKGEN_STEP_EN.
module upd7800_clkgen #(
  parameter int RESET_HOLD = 16
) (
  input  logic       CLK,
  input  logic       RESETB,
  input  logic       CE,
  input  logic       STALL,
`ifdef UPD7800_CLKGEN_STEP_EN
  input  logic       STEP,
`endif
  output logic       CP1_POSEDGE,
  output logic       CP1_NEGEDGE,
  output logic       CP2_POSEDGE,
  output logic       CP2_NEGEDGE,
  output logic       CPU_RESETB,
  output logic [1:0] PHASE,
  output logic       RUNNING
);

  // Handshake: none; every output is a registered level or a one-CLK strobe.
  typedef enum logic [1:0] {
    PH_CP1_RISE = 2'd0,
    PH_CP1_FALL = 2'd1,
    PH_CP2_RISE = 2'd2,
    PH_CP2_FALL = 2'd3
  } phase_t;

  localparam logic [7:0] HOLD_INIT = 8'(RESET_HOLD);

  phase_t     phase_q, phase_d;
  logic [1:0] rst_sync;
  logic       rst_rel;
  logic       frozen_q, frozen_d;
  logic [7:0] hold_q, hold_d;
  logic       cpu_q, cpu_d;
  logic [3:0] strobe_q, strobe_d;
  logic       running_q, running_d;
  logic       adv;
  logic       step_go;

  assign rst_rel = rst_sync[1];

`ifdef UPD7800_CLKGEN_STEP_EN
  logic step_q, arm_q, arm_d;

  assign step_go = arm_q;

  // A STEP rise seen while frozen arms one pass through the phase-3 stall check.
  always_comb begin
    arm_d = arm_q;
    if (adv && phase_q == PH_CP2_FALL) arm_d = 1'b0;
    else if (frozen_q && STEP && !step_q) arm_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      step_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      step_q <= STEP;
      arm_q  <= arm_d;
    end
  end
`else
  assign step_go = 1'b0;
`endif

  always_comb begin
    phase_d   = phase_q;
    frozen_d  = frozen_q;
    hold_d    = hold_q;
    cpu_d     = cpu_q;
    strobe_d  = '0;
    adv       = 1'b0;
    running_d = 1'b0;
    // STALL only matters at the machine-cycle boundary; a started cycle always finishes.
    if (rst_rel && CE) begin
      if (phase_q == PH_CP2_FALL && STALL && !step_go) begin
        frozen_d = 1'b1;
      end else begin
        frozen_d = 1'b0;
        adv      = 1'b1;
      end
    end
    if (adv) begin
      case (phase_q)
        PH_CP1_RISE: phase_d = PH_CP1_FALL;
        PH_CP1_FALL: phase_d = PH_CP2_RISE;
        PH_CP2_RISE: phase_d = PH_CP2_FALL;
        default:     phase_d = PH_CP1_RISE;
      endcase
      strobe_d = 4'b0001 << phase_d;
      if (!cpu_q && phase_d == PH_CP2_FALL && hold_q != 8'd0) hold_d = hold_q - 8'd1;
      if (!cpu_q && phase_d == PH_CP1_RISE && hold_q == 8'd0) cpu_d = 1'b1;
    end
    running_d = cpu_d && !frozen_d;
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      rst_sync  <= 2'b00;
      phase_q   <= PH_CP2_FALL;
      frozen_q  <= 1'b0;
      hold_q    <= HOLD_INIT;
      cpu_q     <= 1'b0;
      strobe_q  <= 4'b0000;
      running_q <= 1'b0;
    end else begin
      rst_sync  <= {rst_sync[0], 1'b1};
      phase_q   <= phase_d;
      frozen_q  <= frozen_d;
      hold_q    <= hold_d;
      cpu_q     <= cpu_d;
      strobe_q  <= strobe_d;
      running_q <= running_d;
    end
  end

  assign CP1_POSEDGE = strobe_q[0];
  assign CP1_NEGEDGE = strobe_q[1];
  assign CP2_POSEDGE = strobe_q[2];
  assign CP2_NEGEDGE = strobe_q[3];
  assign CPU_RESETB  = cpu_q;
  assign PHASE       = phase_q;
  assign RUNNING     = running_q;

endmodule

// File: tb/tb_upd7800_clkgen.sv
// Scoreboard bench for upd7800_clkgen: directed reset/CE/STALL scenarios then random traffic.
module tb_upd7800_clkgen;

  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       rstb = 1'b1;
  logic       ce = 1'b0;
  logic       stall = 1'b0;
  logic       step = 1'b0;
  logic       cp1p, cp1n, cp2p, cp2n, cpu_resetb, running;
  logic [1:0] phase;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];

  // Reference model state
  int m_sync, m_phase, m_cycles;
  bit m_frozen, m_cpu, m_arm, m_step_q;

  upd7800_clkgen #(.RESET_HOLD(HOLD)) dut (
    .CLK(clk),
    .RESETB(rstb),
    .CE(ce),
    .STALL(stall),
`ifdef UPD7800_CLKGEN_STEP_EN
    .STEP(step),
`endif
    .CP1_POSEDGE(cp1p),
    .CP1_NEGEDGE(cp1n),
    .CP2_POSEDGE(cp2p),
    .CP2_NEGEDGE(cp2n),
    .CPU_RESETB(cpu_resetb),
    .PHASE(phase),
    .RUNNING(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected outputs after the coming edge, from the sequencer rules.
  task automatic model_step(input bit r, input bit c, input bit s, input bit st,
                            output logic [7:0] exp);
    bit rel, adv, pre_frozen, old3;
    logic [3:0] strobe;
    strobe = 4'b0000;
    if (!r) begin
      m_sync = 0; m_phase = 3; m_frozen = 0; m_cpu = 0; m_cycles = 0;
      m_arm = 0; m_step_q = 0;
    end else begin
      rel = (m_sync >= 2);
      if (m_sync < 2) m_sync++;
      adv = 0;
      pre_frozen = m_frozen;
      old3 = (m_phase == 3);
      if (rel && c) begin
        if (m_phase == 3 && s && !m_arm) m_frozen = 1;
        else begin m_frozen = 0; adv = 1; end
      end
      if (adv) begin
        m_phase = (m_phase + 1) % 4;
        strobe[m_phase] = 1'b1;
        if (!m_cpu && m_phase == 3) m_cycles++;
        if (!m_cpu && m_phase == 0 && m_cycles >= HOLD) m_cpu = 1;
      end
`ifdef UPD7800_CLKGEN_STEP_EN
      if (adv && old3) m_arm = 0;
      else if (pre_frozen && st && !m_step_q) m_arm = 1;
      m_step_q = st;
`endif
    end
    exp = {strobe, m_cpu, m_cpu && !m_frozen, 2'(m_phase)};
  endtask

  task automatic drive_cycle(input bit r, input bit c, input bit s, input bit st);
    logic [7:0] e;
    @(negedge clk);
    rstb = r; ce = c; stall = s; step = st;
    model_step(r, c, s, st, e);
    exp_q.push_back(e);
  endtask

  // Monitor: every edge the DUT presents a full output vector.
  int cyc = 0;
  initial begin
    logic [7:0] act, e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {cp2n, cp2p, cp1n, cp1p, cpu_resetb, running, phase};
        n_checks++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got %b expected %b", cyc, act, e);
        end
        if ((cp1p + cp1n + cp2p + cp2n) > 1) begin
          n_fail++;
          $display("FAIL strobe_onehot cycle %0d: got %b expected at most one", cyc,
                   {cp2n, cp2p, cp1n, cp1p});
        end
      end
    end
  end

  task automatic measure_release(input bit toggle_ce, input int exp_hold);
    int first, rise;
    first = -1;
    rise = -1;
    for (int n = 1; n <= 400 && rise < 0; n++) begin
      drive_cycle(1'b1, toggle_ce ? (n % 2 == 1) : 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      if (first < 0 && cp1p) first = n;
      if (rise < 0 && cpu_resetb) rise = n;
    end
    check("first_cp1_latency", first, 3);
    check("cpu_resetb_delay", rise - first, exp_hold);
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int guard, stall_left;
    #1 rstb = 1'b0;
    #1;
    check("reset_state", {cp2n, cp2p, cp1n, cp1p, cpu_resetb, running, phase}, 8'b0000_0011);

    hold_reset(3);
    measure_release(1'b0, 64);

    // STALL raised in phase 1: cycle completes, then freeze, then resume.
    guard = 0;
    while (m_phase != 1 && guard < 20) begin drive_cycle(1, 1, 0, 0); guard++; end
    for (int i = 0; i < 10; i++) drive_cycle(1, 1, 1, 0);
    check("frozen_running", int'(m_cpu && !m_frozen), 0);
    for (int i = 0; i < 8; i++) drive_cycle(1, 1, 0, 0);

    hold_reset(3);
    measure_release(1'b1, 128);

    // Reset pulse in phase 2 aborts the cycle and reloads the hold count.
    guard = 0;
    while (m_phase != 2 && guard < 20) begin drive_cycle(1, 1, 0, 0); guard++; end
    hold_reset(2);
    measure_release(1'b0, 64);

`ifdef UPD7800_CLKGEN_STEP_EN
    for (int i = 0; i < 8; i++) drive_cycle(1, 1, 1, 0);
    for (int i = 0; i < 12; i++) drive_cycle(1, 1, 1, 1);
    for (int i = 0; i < 4; i++) drive_cycle(1, 1, 1, 0);
    drive_cycle(1, 1, 1, 1);
    for (int i = 0; i < 8; i++) drive_cycle(1, 0, 1, 0);
    for (int i = 0; i < 8; i++) drive_cycle(1, 1, 1, 0);
    for (int i = 0; i < 4; i++) drive_cycle(1, 1, 0, 0);
`endif

    stall_left = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, c, s, st;
      r = ($urandom_range(0, 399) != 0);
      c = ($urandom_range(0, 3) != 0);
      if (stall_left == 0 && $urandom_range(0, 15) == 0) stall_left = $urandom_range(1, 12);
      s = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      st = ($urandom_range(0, 5) == 0);
      drive_cycle(r, c, s, st);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin @(posedge clk); guard++; end
    #5;
    if (exp_q.size() > 0) check("scoreboard_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
